// File: rtl/mpu_matrix_streamer.sv
// Purpose: captures one flattened SIZE x SIZE signed matrix and streams it out one element per beat, in natural or transposed order.
// Latency: the first element is valid in the cycle after the load; done pulses in the cycle after the final beat is accepted.
// Backpressure: valid/ready on the output; data, index and last hold while stalled, and load_ready stays low until the stream drains.
module mpu_matrix_streamer #(
  parameter int SIZE   = 5,
  parameter int ELEM_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [ELEM_W*SIZE*SIZE-1:0] load_matrix,
  input  logic                       load_transpose,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic [4:0]                 out_index,
  output logic                       out_last,
  output logic                       done,
  output logic                       busy
);

  localparam int NELEM = SIZE * SIZE;
  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       col;
  logic [CNT_W-1:0]       row;
  logic                   transpose;
  logic [ELEM_W-1:0]      mat [NELEM];
  logic [4:0]             idx;
  logic                   at_end;
  logic                   load_fire;
  logic                   beat_fire;

  assign load_fire = (state == IDLE) && load_valid;
  assign beat_fire = (state == STREAM) && out_ready;

  // Flat element index and end-of-matrix flag from the current counters.
  always_comb begin
    idx    = 5'(row) + 5'(SIZE) * 5'(col);
    at_end = (col == CNT_MAX) && (row == CNT_MAX);
  end

  assign out_index = idx;
  assign out_data  = mat[idx];
  assign out_last  = out_valid && at_end;

  // Snapshot the whole matrix on a load; the stored copy is then independent of the input bus.
  always_ff @(posedge clock) begin
    if (load_fire && !reset) begin
      for (int k = 0; k < NELEM; k++) begin
        mat[k] <= load_matrix[ELEM_W*k +: ELEM_W];
      end
    end
  end

  // Control FSM: walks the col/row counters in the requested order and produces the registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      col        <= '0;
      row        <= '0;
      transpose  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            transpose  <= load_transpose;
            col        <= '0;
            row        <= '0;
            state      <= STREAM;
            load_ready <= 1'b0;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        STREAM: begin
          if (beat_fire) begin
            if (at_end) begin
              // Final element accepted: park the counters and report completion next cycle.
              state      <= IDLE;
              col        <= '0;
              row        <= '0;
              load_ready <= 1'b1;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (!transpose) begin
              // Natural order: row is the fast counter.
              if (row == CNT_MAX) begin
                row <= '0;
                col <= col + CNT_ONE;
              end else begin
                row <= row + CNT_ONE;
              end
            end else begin
              // Transposed order: col is the fast counter.
              if (col == CNT_MAX) begin
                col <= '0;
                row <= row + CNT_ONE;
              end else begin
                col <= col + CNT_ONE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Purpose: directed self-checking bench for mpu_matrix_streamer.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready is held high or toggled pseudo-randomly depending on the scenario.
module tb_mpu_matrix_streamer;

  logic         clock = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [199:0] load_matrix;
  logic         load_transpose;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [4:0]   out_index;
  logic         out_last;
  logic         done;
  logic         busy;

  int vecs = 0;
  int errs = 0;

  wire [16:0] got = {out_valid, busy, out_index, out_data, out_last, done};

  mpu_matrix_streamer #(.SIZE(5), .ELEM_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_matrix    (load_matrix),
    .load_transpose (load_transpose),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last),
    .done           (done),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] elem(input int kind, input int i);
    case (kind)
      0:       return 8'(i + 1);
      1:       return (i == 0) ? 8'h80 : (i == 1) ? 8'hFF : 8'h7F;
      default: return 8'(100 + i);
    endcase
  endfunction

  function automatic logic [199:0] mk(input int kind);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 25; i++) m[8*i +: 8] = elem(kind, i);
    return m;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_valid = 1'b1; load_matrix = mk(0);
    load_transpose = 1'b0; out_ready = 1'b1;
    step(); step();
    vecs++;
    if ({load_ready, out_valid, busy, done, out_last, out_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      errs++;
      $display("FAIL reset_state: got %b want %b", {load_ready, out_valid, busy, done, out_last, out_index}, 10'b1000000000);
    end
    reset = 1'b0; load_valid = 1'b0;
    step();
    vecs++;
    if ({load_ready, out_valid, busy, done} !== 4'b1000) begin
      errs++;
      $display("FAIL reset_no_load: got %b want 1000", {load_ready, out_valid, busy, done});
    end
  endtask

  task automatic test_order(input bit tr);
    int i;
    logic [16:0] want;
    load_matrix = mk(0); load_transpose = tr; out_ready = 1'b1; load_valid = 1'b1;
    vecs++;
    if (load_ready !== 1'b1) begin
      errs++;
      $display("FAIL order%0d_load_ready: got %b want 1", tr, load_ready);
    end
    step();
    load_valid = 1'b0; load_matrix = '1; load_transpose = ~tr;
    for (int k = 0; k < 25; k++) begin
      i = tr ? (k / 5) + 5 * (k % 5) : k;
      want = {1'b1, 1'b1, 5'(i), elem(0, i), (k == 24), 1'b0};
      vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL order%0d_beat%0d: got %h want %h", tr, k, got, want);
      end
      step();
    end
    vecs++;
    if ({out_valid, busy, load_ready, done} !== 4'b0011) begin
      errs++;
      $display("FAIL order%0d_done: got %b want 0011", tr, {out_valid, busy, load_ready, done});
    end
    step();
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL order%0d_done_pulse: got %b want 0", tr, done);
    end
  endtask

  task automatic test_sign_backpressure;
    int b;
    int cyc;
    int stalls;
    bit stalled;
    logic [16:0] held;
    b = 0; cyc = 0; stalls = 0; stalled = 1'b0; held = '0;
    load_matrix = mk(1); load_transpose = 1'b0; out_ready = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0; load_matrix = mk(0);
    while (b < 25 && cyc < 400) begin
      if (stalled) begin
        vecs++;
        if (got !== held) begin
          errs++;
          $display("FAIL stall_hold_beat%0d: got %h want %h", b, got, held);
        end
      end
      stalled = 1'b0;
      vecs++;
      if (out_valid !== 1'b1) begin
        errs++;
        $display("FAIL bp_valid_beat%0d: got %b want 1", b, out_valid);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) begin
        vecs++;
        if ({out_index, out_data, out_last} !== {5'(b), elem(1, b), (b == 24)}) begin
          errs++;
          $display("FAIL bp_beat%0d: got %h want %h", b, {out_index, out_data, out_last}, {5'(b), elem(1, b), (b == 24)});
        end
        b++;
      end else begin
        held = got;
        stalled = 1'b1;
        stalls++;
      end
      step();
      cyc++;
    end
    vecs++;
    if (b != 25) begin
      errs++;
      $display("FAIL bp_timeout: got %0d beats want 25", b);
    end
    vecs++;
    if ({out_valid, done} !== 2'b01) begin
      errs++;
      $display("FAIL bp_done: got %b want 01", {out_valid, done});
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_load_while_busy;
    logic [17:0] want;
    load_matrix = mk(0); load_transpose = 1'b0; out_ready = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (k == 3) begin
        load_valid = 1'b1;
        load_matrix = mk(2);
      end
      want = {1'b1, 1'b1, 5'(k), elem(0, k), (k == 24), 1'b0, 1'b0};
      vecs++;
      if ({got, load_ready} !== want) begin
        errs++;
        $display("FAIL busy_a_beat%0d: got %h want %h", k, {got, load_ready}, want);
      end
      step();
    end
    vecs++;
    if ({out_valid, load_ready, done} !== 3'b011) begin
      errs++;
      $display("FAIL busy_done: got %b want 011", {out_valid, load_ready, done});
    end
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      vecs++;
      if (got !== {1'b1, 1'b1, 5'(k), elem(2, k), (k == 24), 1'b0}) begin
        errs++;
        $display("FAIL busy_b_beat%0d: got %h want %h", k, got, {1'b1, 1'b1, 5'(k), elem(2, k), (k == 24), 1'b0});
      end
      step();
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL busy_b_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid_stream;
    int seen;
    int i;
    seen = 0;
    load_matrix = mk(0); load_transpose = 1'b0; out_ready = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vecs++;
      if (got !== {1'b1, 1'b1, 5'(k), elem(0, k), 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL rst_pre_beat%0d: got %h want %h", k, got, {1'b1, 1'b1, 5'(k), elem(0, k), 1'b0, 1'b0});
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++;
    if ({out_valid, busy, load_ready, done, out_last, out_index} !== {4'b0010, 1'b0, 5'd0}) begin
      errs++;
      $display("FAIL rst_mid_state: got %b want 0010000000", {out_valid, busy, load_ready, done, out_last, out_index});
    end
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1 || out_valid === 1'b1) seen++;
      step();
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL rst_no_done: got %0d activity cycles want 0", seen);
    end
    load_matrix = mk(2); load_transpose = 1'b1; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      i = (k / 5) + 5 * (k % 5);
      vecs++;
      if (got !== {1'b1, 1'b1, 5'(i), elem(2, i), (k == 24), 1'b0}) begin
        errs++;
        $display("FAIL rst_restart_beat%0d: got %h want %h", k, got, {1'b1, 1'b1, 5'(i), elem(2, i), (k == 24), 1'b0});
      end
      step();
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL rst_restart_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int nb;
    nb = 0;
    load_matrix = mk(0); load_transpose = 1'b0; out_ready = 1'b1; load_valid = 1'b1;
    step();
    load_matrix = mk(2);
    for (int k = 0; k < 25; k++) begin
      vecs++;
      if (got !== {1'b1, 1'b1, 5'(k), elem(0, k), (k == 24), 1'b0}) begin
        errs++;
        $display("FAIL b2b_a_beat%0d: got %h want %h", k, got, {1'b1, 1'b1, 5'(k), elem(0, k), (k == 24), 1'b0});
      end else begin
        nb++;
      end
      step();
    end
    vecs++;
    if ({out_valid, load_ready, done} !== 3'b011) begin
      errs++;
      $display("FAIL b2b_gap: got %b want 011", {out_valid, load_ready, done});
    end
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      vecs++;
      if (got !== {1'b1, 1'b1, 5'(k), elem(2, k), (k == 24), 1'b0}) begin
        errs++;
        $display("FAIL b2b_b_beat%0d: got %h want %h", k, got, {1'b1, 1'b1, 5'(k), elem(2, k), (k == 24), 1'b0});
      end else begin
        nb++;
      end
      step();
    end
    vecs++;
    if (nb != 50 || done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_total: got %0d beats done=%b want 50 beats done=1", nb, done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_sign_backpressure();
    test_load_while_busy();
    test_reset_mid_stream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mpu_matrix_streamer.md
# mpu_matrix_streamer

Matrix unloader for the MPU datapath. Captures one flattened 5x5 signed 8-bit result matrix, as produced by the element-wise MPU operation units, and streams it out one element per beat over a valid/ready byte interface toward the host/bus side. It is the reading end of the operation units' flat matrix output. It optionally emits the elements in transposed order.

## Interface
- `SIZE`, 5, matrix dimension (SIZE x SIZE elements)
- `ELEM_W`, 8, element width in bits
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `load_valid`  in  1  `load_matrix` is valid
- `load_ready`  out  1  block idle, can accept a matrix
- `load_matrix`  in  ELEM_W*SIZE*SIZE (200)  flat matrix; element (col,row) at bits [ELEM_W*(row + SIZE*col) +: ELEM_W]
- `load_transpose`  in  1  sampled with the load: 0 = natural order, 1 = transposed order
- `out_valid`  out  1  `out_data` holds a valid element
- `out_ready`  in  1  downstream accepts the element
- `out_data`  out  ELEM_W  signed element value
- `out_index`  out  5  flat index i = row + SIZE*col of the current element
- `out_last`  out  1  current element is the final one of the matrix
- `done`  out  1  one-cycle pulse after the final beat is accepted
- `busy`  out  1  high while streaming

## Operation
- States:
  - IDLE: `load_ready`=1. A load occurs on load_valid && load_ready. It registers the full matrix and `load_transpose`, clears the col/row counters, and goes to STREAM.
  - STREAM: `out_valid`=1 and `busy`=1.
    - On out_valid && out_ready the counters advance.
    - On the beat where `out_last`=1, go to IDLE and pulse `done` in the following cycle.
- Counters: `col` and `row`, each 0..SIZE-1.
  - Natural order: `row` is the fast counter. When it wraps 4→0, `col` increments. Emitted i sequence: 0,1,2,…,24.
  - Transposed order: `col` is the fast counter. When it wraps 4→0, `row` increments. Emitted i sequence: 0,5,10,15,20,1,6,…,24.
- `out_data` = captured[ELEM_W*(row+SIZE*col) +: ELEM_W]. `out_index` = row+SIZE*col. `out_last` = (col==4 && row==4), in both orders.
- No arithmetic is performed. Values pass through bit-exact, so sign is preserved.
- In STREAM, `load_valid` is ignored; `load_ready`=0 and the captured matrix is not overwritten.
- The registered matrix is independent of `load_matrix` after capture. The input may change freely.

## Timing
- Reset values: state IDLE, `load_ready`=1, `out_valid`=0, `busy`=0, `done`=0, `out_last`=0, `out_index`=0, counters 0. `out_data` contents are don't-care while `out_valid`=0.
- A load accepted at edge N gives `out_valid`=1 with element i=0 from cycle N+1.
- With `out_ready` held high: 25 beats in cycles N+1..N+25, `done` high in cycle N+26, `load_ready` high from cycle N+26. A new load can be accepted in cycle N+26, so back-to-back matrices take 26 cycles each.
- Backpressure: while out_valid && !out_ready, `out_data`, `out_index` and `out_last` hold stable. A stall of any length loses and duplicates nothing.
- `out_valid` never drops in STREAM until the last beat is accepted.
- Reset asserted mid-stream: at the next edge all outputs take their reset values and the partial matrix is discarded. No `done` pulse.
- Reset and load_valid in the same cycle: reset wins and no load occurs.

## Test plan
- Natural order: load element i = i+1 (1..25), transpose=0, `out_ready`=1. Required: `out_data` 1..25 on consecutive cycles N+1..N+25, `out_index` 0..24, `out_last` only on index 24, `done` in cycle N+26.
- Transposed order: same matrix, transpose=1. Required: `out_index` 0,5,10,15,20,1,…,24 and `out_data` 1,6,11,16,21,2,…,25. `out_last` on index 24.
- Sign and backpressure: element 0 = -128 (8'h80), element 1 = -1 (8'hFF), the rest 8'h7F. Toggle `out_ready` pseudo-randomly. Required: 25 accepted beats with exactly those values, and outputs stable during every stall.
- Load while busy: during a stream, drive `load_valid`=1 with a different matrix. Required: `load_ready`=0, the original stream completes unchanged, and the second matrix is accepted only in the `done` cycle.
- Reset mid-stream: assert reset after 10 beats. Required: `out_valid`=0, `busy`=0, `load_ready`=1 the next cycle, and no `done`. A new load then restarts at index 0.
- Back-to-back: two loads with `load_valid` held high. Required: the second matrix's index 0 appears in cycle N+27 and 50 beats are total in order.
